// File: rtl/operand_packer_pkg.sv
// rtl/operand_packer_pkg.sv - shared constants for the operand packer
// Holds the packer FSM state encoding, the default geometry and the
// half-word width helper used by the interface, top and FIFO.
package operand_packer_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 4;

  // Operand width is half of the packed output word.
  function automatic int half_of(input int width);
    return width / 2;
  endfunction

  // Occupancy counter needs one extra bit to represent "full".
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int HALF = DEFAULT_WIDTH / 2;

  // FSM state encoding.
  localparam logic [0:0] WAIT_A = 1'b0;
  localparam logic [0:0] WAIT_B = 1'b1;

endpackage

// File: rtl/operand_packer_if.sv
// rtl/operand_packer_if.sv - operand/packed-word handshake bundle
// Operand side : in_data, in_valid, in_last (to packer), in_ready (from packer)
// Packed side  : out_data, out_valid, level, odd_pad (from packer), out_ready (to packer)
// master drives operands and consumes words; slave is the packer.
interface operand_packer_if
  import operand_packer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) ();

  logic [WIDTH/2-1:0]        in_data;
  logic                      in_valid;
  logic                      in_last;
  logic                      in_ready;
  logic [WIDTH-1:0]          out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [$clog2(DEPTH):0]    level;
  logic                      odd_pad;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, level, odd_pad
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, level, odd_pad
  );

endinterface

// File: rtl/operand_packer_fifo.sv
// rtl/operand_packer_fifo.sv - output word FIFO for the operand packer
// Ports: clk, rst (sync, active-low), push/push_data, pop/pop_data,
//        full, empty, level (occupancy).
// pop_data shows the head entry while non-empty and the last popped word
// (0 after reset) while empty.
module packer_fifo
  import operand_packer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          pop_data,
  output logic                      full,
  output logic                      empty,
  output logic [level_w(DEPTH)-1:0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    last_d   = last_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      // DEPTH is a power of two, so the pointer wraps by overflow.
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      last_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage needs no reset: it is only read while its slot is occupied.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      last_q   <= last_d;
    end
  end

  assign pop_data = empty ? last_q : mem_q[rd_ptr_q];
  assign level    = level_q;

endmodule

// File: rtl/operand_packer.sv
// rtl/operand_packer.sv - pairs half-width operands into {B, A} words
// Ports: clk, rst (sync, active-low), bus (operand_packer_if.slave):
//   operands in via in_data/in_valid/in_last/in_ready,
//   packed words out via out_data/out_valid/out_ready, plus level and
//   the sticky odd_pad flag (burst ended on an unpaired A).
module operand_packer
  import operand_packer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  operand_packer_if.slave    bus
);

  localparam int HW = half_of(WIDTH);

  logic [0:0]       state_q, state_d;
  logic [HW-1:0]    a_q, a_d;
  logic             odd_pad_q, odd_pad_d;
  logic             run_q, run_d;
  logic             in_ready;
  logic             accept;
  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             full;
  logic             empty;

  // run_q holds in_ready low on the reset cycle and releases it one
  // cycle after rst deasserts. in_ready ignores a same-cycle pop.
  assign in_ready = run_q & ~full;
  assign accept   = bus.in_valid & in_ready;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    odd_pad_d = odd_pad_q;
    run_d     = 1'b1;
    push      = 1'b0;
    push_data = '0;
    if (accept) begin
      case (state_q)
        WAIT_A: begin
          if (bus.in_last) begin
            push      = 1'b1;
            push_data = {{HW{1'b0}}, bus.in_data};
            odd_pad_d = 1'b1;
          end else begin
            a_d     = bus.in_data;
            state_d = WAIT_B;
          end
        end
        WAIT_B: begin
          push      = 1'b1;
          push_data = {bus.in_data, a_q};
          state_d   = WAIT_A;
        end
        default: state_d = WAIT_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= WAIT_A;
      a_q       <= '0;
      odd_pad_q <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      odd_pad_q <= odd_pad_d;
      run_q     <= run_d;
    end
  end

  packer_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (bus.out_ready),
    .pop_data  (bus.out_data),
    .full      (full),
    .empty     (empty),
    .level     (bus.level)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = ~empty;
  assign bus.odd_pad   = odd_pad_q;

endmodule

// File: tb/tb_operand_packer.sv
// tb/tb_operand_packer.sv - self-checking bench for operand_packer
module tb_operand_packer;

  localparam int W = 32;
  localparam int D = 4;
  localparam int H = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  operand_packer_if #(.WIDTH(W), .DEPTH(D)) bus ();

  operand_packer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queue of words that must come out, in order.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_last = '0;
  logic [H-1:0] m_a = '0;
  bit           m_have_a = 0;
  bit           m_odd = 0;
  bit           m_run = 0;
  bit           m_live = 0;
  bit           m_take;
  int           acc_cnt = 0;
  logic [W-1:0] dut_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      exp_q.delete();
      m_last   = '0;
      m_a      = '0;
      m_have_a = 0;
      m_odd    = 0;
      m_run    = 0;
      m_live   = 1;
    end else begin
      m_take = m_run && (exp_q.size() < D);
      if (bus.out_ready && exp_q.size() != 0) m_last = exp_q.pop_front();
      if (bus.in_valid && m_take) begin
        acc_cnt++;
        if (!m_have_a) begin
          if (bus.in_last) begin
            exp_q.push_back({16'h0000, bus.in_data});
            m_odd = 1;
          end else begin
            m_a      = bus.in_data;
            m_have_a = 1;
          end
        end else begin
          exp_q.push_back({bus.in_data, m_a});
          m_have_a = 0;
        end
      end
      m_run = 1;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("in_ready", bus.in_ready, m_run && (exp_q.size() < D));
      check("out_valid", bus.out_valid, exp_q.size() != 0);
      check("level", bus.level, exp_q.size());
      check("odd_pad", bus.odd_pad, m_odd);
      check("out_data", bus.out_data, (exp_q.size() != 0) ? exp_q[0] : m_last);
      if (bus.out_valid && bus.out_ready) dut_log.push_back(bus.out_data);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [H-1:0] d, input bit last);
    int start = acc_cnt;
    bit got = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk);
      #1;
      if (acc_cnt != start) got = 1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("send_accepted", got, 1'b1);
  endtask

  // Row of independent full adders, every bit fed the same carry-in.
  function automatic logic [H-1:0] fa_row(input logic [H-1:0] a, input logic [H-1:0] b, input logic cin);
    logic [H-1:0] s;
    for (int i = 0; i < H; i++) s[i] = a[i] ^ b[i] ^ cin;
    return s;
  endfunction

  logic [W-1:0] bp_words [5] = '{32'h01010100, 32'h01030102, 32'h01050104, 32'h01070106, 32'h01090108};
  logic [W-1:0] word;

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b0;
    tick(2);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_level", bus.level, 3'd0);
    check("rst_out_data", bus.out_data, 32'h0);
    check("rst_odd_pad", bus.odd_pad, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b0);
    rst = 1'b1;
    tick(1);
    check("post_rst_in_ready", bus.in_ready, 1'b1);

    // Paired operands.
    bus.out_ready = 1'b1;
    dut_log.delete();
    send(16'h1234, 0);
    send(16'hABCD, 0);
    check("pair_out_data", bus.out_data, 32'hABCD1234);
    check("pair_out_valid", bus.out_valid, 1'b1);
    tick(1);
    check("pair_level", bus.level, 3'd0);
    check("pair_hold", bus.out_data, 32'hABCD1234);

    // Odd burst.
    dut_log.delete();
    send(16'h0001, 0);
    send(16'h0002, 0);
    send(16'h0003, 1);
    tick(2);
    check("odd_count", dut_log.size(), 2);
    check("odd_word0", dut_log[0], 32'h00020001);
    check("odd_word1", dut_log[1], 32'h00000003);
    check("odd_pad_set", bus.odd_pad, 1'b1);

    // Backpressure.
    bus.out_ready = 1'b0;
    dut_log.delete();
    for (int i = 0; i < 8; i++) send(16'h0100 + 16'(i), 0);
    check("bp_level_full", bus.level, 3'd4);
    check("bp_in_ready_low", bus.in_ready, 1'b0);
    fork
      begin
        send(16'h0108, 0);
        send(16'h0109, 0);
      end
      begin
        tick(3);
        check("bp_stall_ready", bus.in_ready, 1'b0);
        check("bp_stall_level", bus.level, 3'd4);
        bus.out_ready = 1'b1;
      end
    join
    tick(4);
    check("bp_count", dut_log.size(), 5);
    for (int k = 0; k < 5; k++) check("bp_word", dut_log[k], bp_words[k]);
    check("odd_pad_sticky", bus.odd_pad, 1'b1);

    // Simultaneous push and pop at level 2, past pointer wrap.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(16'h0200 + 16'(i), 0);
    check("pp_level_start", bus.level, 3'd2);
    for (int p = 0; p < 10; p++) begin
      bus.out_ready = 1'b0;
      send(16'h0210 + 16'(2 * p), 0);
      bus.out_ready = 1'b1;
      send(16'h0211 + 16'(2 * p), 0);
      bus.out_ready = 1'b0;
      check("pp_level_hold", bus.level, 3'd2);
    end
    bus.out_ready = 1'b1;
    tick(4);
    check("pp_drained", bus.level, 3'd0);

    // Reset mid-operation.
    dut_log.delete();
    send(16'h5555, 0);
    rst = 1'b0;
    tick(1);
    check("mid_rst_in_ready", bus.in_ready, 1'b0);
    check("mid_rst_odd_pad", bus.odd_pad, 1'b0);
    check("mid_rst_out_data", bus.out_data, 32'h0);
    rst = 1'b1;
    tick(1);
    check("mid_rst_ready_back", bus.in_ready, 1'b1);
    send(16'h0011, 0);
    send(16'h0022, 0);
    tick(2);
    check("mid_rst_count", dut_log.size(), 1);
    check("mid_rst_word", dut_log[0], 32'h00220011);

    // End-to-end through the adder stage.
    send(16'h00FF, 0);
    send(16'h0F0F, 0);
    word = bus.out_data;
    check("e2e_word", word, 32'h0F0F00FF);
    check("e2e_sum_cin0", fa_row(word[15:0], word[31:16], 1'b0), 16'h0FF0);
    check("e2e_sum_cin1", fa_row(word[15:0], word[31:16], 1'b1), 16'hF00F);
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/operand_packer.md
OPERAND_PACKER -- requirements
Module: operand_packer

Interface
REQ-001 Parameter WIDTH, default 32: packed output word width; SHALL be even.
REQ-002 Parameter DEPTH, default 4: output FIFO entries; SHALL be a power of two, at least 2.
REQ-003 clk  input  1: rising-edge clock for all state.
REQ-004 rst  input  1: reset, synchronous, active-low.
REQ-005 in_data  input  WIDTH/2: operand word.
REQ-006 in_valid  input  1: in_data is valid this cycle.
REQ-007 in_last  input  1: qualified by in_valid; marks the final operand of a burst.
REQ-008 in_ready  output  1: packer accepts an operand this cycle.
REQ-009 out_data  output  WIDTH: packed word {B, A}; A in bits [WIDTH/2-1:0], B in bits [WIDTH-1:WIDTH/2].
REQ-010 out_valid  output  1: out_data holds an unconsumed word.
REQ-011 out_ready  input  1: downstream adder stage consumes the word.
REQ-012 level  output  clog2(DEPTH)+1: current FIFO occupancy.
REQ-013 odd_pad  output  1: sticky flag; set when a burst ends on an unpaired A.

Function
REQ-014 An operand SHALL be accepted only on a cycle where in_valid=1 and in_ready=1.
REQ-015 in_ready SHALL be 1 exactly when level<DEPTH; it SHALL NOT depend on a same-cycle pop.
REQ-016 The FSM SHALL have two states: WAIT_A and WAIT_B.
REQ-017 WAIT_A with an accepted operand and in_last=0: latch it as A; go to WAIT_B.
REQ-018 WAIT_A with an accepted operand and in_last=1: push {0, operand}; set odd_pad; stay in WAIT_A.
REQ-019 WAIT_B with an accepted operand: push {operand, A}; go to WAIT_A. in_last is ignored.
REQ-020 A push SHALL make the word visible at out_data/out_valid on the next cycle (latency 1 from acceptance of B).
REQ-021 Pop occurs when out_valid=1 and out_ready=1. The FIFO SHALL present the next entry on the following cycle.
REQ-022 A simultaneous push and pop SHALL leave level unchanged and preserve word order.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH.
REQ-024 When empty, out_valid SHALL be 0 and out_data SHALL hold the last popped value (0 after reset).
REQ-025 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 odd_pad SHALL remain set until reset.

Reset
REQ-027 On a clk edge with rst=0 the packer SHALL take the reset values: state WAIT_A, A register 0, pointers 0, level 0, out_valid 0, out_data 0, odd_pad 0, in_ready 0.
REQ-028 A reset mid-operation SHALL discard the pending A and all FIFO contents; no partial word is emitted afterwards.
REQ-029 in_ready SHALL go to 1 on the first cycle after rst returns to 1.

Structure
REQ-030 The shared package SHALL hold the FSM state encoding (WAIT_A=0, WAIT_B=1) and the HALF=WIDTH/2 constant.
REQ-031 The FIFO SHALL be one sub-module, packer_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/level ports). The FSM and A register SHALL live in operand_packer.

Verification
REQ-032 Paired operands: stream 0x1234, 0xABCD with out_ready=1 -> out_data=0xABCD1234, out_valid=1 on the cycle after 0xABCD is accepted; level returns to 0.
REQ-033 Odd burst: 0x0001 (last=0), 0x0002 (last=0), 0x0003 (last=1) -> words 0x00020001 then 0x00000003; odd_pad=1.
REQ-034 Backpressure: out_ready=0 with 10 operands streamed -> in_ready drops after 8 accepted (level=4); releasing out_ready drains 4 words in order, and the remaining 2 operands then form the 5th word.
REQ-035 Simultaneous push and pop at level=2 -> level stays 2; the output sequence matches the input order across pointer wrap after more than 8 pushes.
REQ-036 Reset mid-operation: accept A=0x5555, assert rst=0 for 1 cycle, then send 0x0011, 0x0022 -> only 0x00220011 emitted; 0x5555 never appears.
REQ-037 End-to-end: drive the full adder stage from out_data with out_ready=1 and A=0x00FF, B=0x0F0F -> bits [15:0] of the adder result equal 0x0FF0 with cin=0, or 0xF00F with cin=1.
